quad_sum_acc: RTL and testbench
===============================

# quad_sum_acc

Sequential accumulator that consumes the four shifted partial values produced by the calculator's quad shift stage (shiftVal0..shiftVal3) and sums them into a single 10-bit result, adding one operand per clock. Sits directly downstream of the quad shift stage and upstream of the result/display register. A start/busy/done handshake lets the calculator control FSM sequence multiply operations.

## Interface
- No parameters; widths are fixed.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- start  input  1  request a new sum; sampled only when busy=0.
- shiftVal0  input  8  operand 0 (shift 0 lane).
- shiftVal1  input  8  operand 1 (shift 1 lane).
- shiftVal2  input  8  operand 2 (shift 2 lane).
- shiftVal3  input  8  operand 3 (shift 3 lane).
- busy  output  1  high while accumulating.
- done  output  1  one-cycle pulse when sum is valid.
- sum  output  10  unsigned sum of the four captured operands; held until next accepted start.
- ovf  output  1  sum exceeds 8 bits (see Configuration).

## Operation
- FSM states: IDLE, ACC, DONE. Reset state IDLE.
- IDLE/DONE: start=1 at an edge -> latch shiftVal0..3 into operand registers, clear accumulator to 0, idx<=0, go ACC. start=0 in DONE -> IDLE; in IDLE -> stay.
- ACC: each edge acc <= acc + zero-extended op[idx], idx <= idx+1 (2-bit). On the edge where idx=3 the final add happens, sum <= acc + op[3], go DONE.
- Operands sampled only at the accepting edge; changes on shiftValN during ACC have no effect.
- start while busy=1 is ignored (not queued).
- Arithmetic: 10-bit unsigned, max 4×255=1020, cannot wrap.
- sum register updates only on the final ACC edge; holds its value through IDLE and through the next ACC until that run's final add.
- Reset mid-operation: at the reset edge state->IDLE, acc/sum/idx/operands->0, busy/done/ovf->0; partial sum discarded, no done pulse.
- Reset values: busy=0, done=0, sum=0, ovf=0.

## Timing
- Edge E0: start accepted. busy=1 after E0 through E4 (4 cycles).
- Edges E1..E4: add op0..op3. After E4: busy=0, done=1, sum valid.
- done high exactly one cycle (DONE state); latency start-edge to done = 4 cycles; sum valid from E4 onward.
- Back-to-back: start=1 during the done cycle accepted at E5; busy high again after E5, next done after E9. Throughput one sum per 5 cycles.
- busy and done are registered, never combinational from start.

## Configuration
- Macro QUAD_SUM_OVF_EN.
- Defined: ovf register present; updated together with sum, ovf <= (final sum > 255), i.e. |sum[9:8]; held with sum; cleared by reset.
- Undefined: no ovf register; ovf tied to 0; all other behaviour identical.

## Test plan
- Reset: hold rst_n=0 two cycles mid-ACC (after E2) -> next cycle busy=0, done=0, sum=0, ovf=0; no done pulse follows.
- Basic: shiftVal0..3 = 1,2,4,8, start one cycle -> busy 4 cycles, done pulse after E4, sum=15, ovf=0.
- Max: all operands 255 -> sum=1020 (10'h3FC); ovf=1 with QUAD_SUM_OVF_EN, ovf=0 without.
- Input isolation: start with 10,20,30,40, then change all inputs to 255 during ACC -> sum=100.
- Ignored start: pulse start at E2 during busy -> single done after E4, no second run, busy=0 after done.
- Back-to-back: start held high continuously with operands 1,1,1,1 then 2,2,2,2 at E5 -> done after E4 with sum=4, done after E9 with sum=8; sum stays 4 between E4 and E9.

Source files
------------

// File: rtl/quad_sum_acc_if.sv
// quad_sum_acc_if: bundles the start/busy/done handshake, the four shifted
// operand lanes and the sum/overflow result between the calculator control
// side (master) and the quad_sum_acc accumulator (slave).
interface quad_sum_acc_if;
  logic       start;
  logic [7:0] shiftVal0;
  logic [7:0] shiftVal1;
  logic [7:0] shiftVal2;
  logic [7:0] shiftVal3;
  logic       busy;
  logic       done;
  logic [9:0] sum;
  logic       ovf;

  modport master (
    output start, shiftVal0, shiftVal1, shiftVal2, shiftVal3,
    input  busy, done, sum, ovf
  );

  modport slave (
    input  start, shiftVal0, shiftVal1, shiftVal2, shiftVal3,
    output busy, done, sum, ovf
  );
endinterface : quad_sum_acc_if

// File: rtl/quad_sum_acc.sv
// quad_sum_acc: sequential four-operand accumulator behind the quad shift
// stage. On an accepted start it captures shiftVal0..3, then adds one
// operand per clock into a 10-bit accumulator and publishes the result with
// a one-cycle done pulse four cycles later.
//
// Optional feature: define QUAD_SUM_OVF_EN to build the overflow flag
// register (set when the final sum does not fit in 8 bits). Without it the
// ovf output is tied low.
module quad_sum_acc (
  input  logic           clk,
  input  logic           rst_n,
  quad_sum_acc_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q;
  logic [7:0] op_q [4];
  logic [9:0] acc_q;
  logic [9:0] sum_q;
  logic [1:0] idx_q;
  logic       busy_q;
  logic       done_q;

  logic       accept_d;
  logic       last_add_d;
  logic [9:0] acc_d;

  // Start acceptance and the running add; start is ignored while accumulating.
  // NOTE: every always_comb output is given a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    accept_d   = 1'b0;
    last_add_d = 1'b0;
    acc_d      = acc_q + {2'b00, op_q[idx_q]};
    if (state_q != ACC) begin
      accept_d = bus.start;
    end
    if ((state_q == ACC) && (idx_q == 2'd3)) begin
      last_add_d = 1'b1;
    end
  end

  // Control FSM with registered busy/done, operand capture and accumulation.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      // NOTE: the small operand file is explicitly cleared because a reset
      // must discard any partially captured operation.
      for (int i = 0; i < 4; i++) begin
        op_q[i] <= '0;
      end
      acc_q  <= '0;
      sum_q  <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (accept_d) begin
            op_q[0] <= bus.shiftVal0;
            op_q[1] <= bus.shiftVal1;
            op_q[2] <= bus.shiftVal2;
            op_q[3] <= bus.shiftVal3;
            acc_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ACC;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        ACC: begin
          acc_q <= acc_d;
          idx_q <= idx_q + 2'd1;
          if (last_add_d) begin
            sum_q   <= acc_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;

`ifdef QUAD_SUM_OVF_EN
  logic ovf_q;

  // Overflow flag tracks the published sum: loaded on the final add, held after.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (last_add_d) begin
      ovf_q <= |acc_d[9:8];
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule : quad_sum_acc

// File: tb/tb_quad_sum_acc.sv
// tb_quad_sum_acc: directed self-checking bench for quad_sum_acc with
// hand-computed expected sums, timing of busy/done, input isolation,
// ignored start, back-to-back runs and mid-operation reset.
module tb_quad_sum_acc;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  quad_sum_acc_if bus ();

  quad_sum_acc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef QUAD_SUM_OVF_EN
  localparam logic OVF_MAX = 1'b1;
`else
  localparam logic OVF_MAX = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    bus.shiftVal0 = a;
    bus.shiftVal1 = b;
    bus.shiftVal2 = c;
    bus.shiftVal3 = d;
  endtask

  // One full run: accept at E0, check busy E0..E3, done/sum/ovf after E4,
  // then done drops and sum holds. Optionally scrambles inputs during ACC.
  task automatic run_sum(input string tag,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d,
                         input logic [9:0] exp_sum, input logic exp_ovf,
                         input bit scramble);
    set_ops(a, b, c, d);
    bus.start = 1'b1;
    step();                                   // E0
    bus.start = 1'b0;
    if (scramble) set_ops(8'd255, 8'd255, 8'd255, 8'd255);
    for (int e = 0; e < 4; e++) begin
      check({tag, "_busy"}, bus.busy, 1'b1);
      check({tag, "_nodone"}, bus.done, 1'b0);
      step();                                 // E1..E4
    end
    check({tag, "_busy_end"}, bus.busy, 1'b0);
    check({tag, "_done"}, bus.done, 1'b1);
    check({tag, "_sum"}, bus.sum, exp_sum);
    check({tag, "_ovf"}, bus.ovf, exp_ovf);
    step();
    check({tag, "_done_pulse"}, bus.done, 1'b0);
    check({tag, "_sum_hold"}, bus.sum, exp_sum);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    set_ops(8'd0, 8'd0, 8'd0, 8'd0);

    // Reset state
    step();
    step();
    rst_n = 1'b1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_sum", bus.sum, 10'd0);
    check("rst_ovf", bus.ovf, 1'b0);

    // Basic, max, input isolation
    run_sum("basic", 8'd1, 8'd2, 8'd4, 8'd8, 10'd15, 1'b0, 1'b0);
    run_sum("max", 8'd255, 8'd255, 8'd255, 8'd255, 10'h3FC, OVF_MAX, 1'b0);
    run_sum("iso", 8'd10, 8'd20, 8'd30, 8'd40, 10'd100, 1'b0, 1'b1);

    // Ignored start: pulse start between E2 and E3 while busy
    set_ops(8'd3, 8'd5, 8'd7, 8'd9);
    bus.start = 1'b1;
    step();                                   // E0
    bus.start = 1'b0;
    step();                                   // E1
    step();                                   // E2
    bus.start = 1'b1;
    step();                                   // E3 (start ignored)
    bus.start = 1'b0;
    check("ign_busy_e3", bus.busy, 1'b1);
    step();                                   // E4
    check("ign_done", bus.done, 1'b1);
    check("ign_sum", bus.sum, 10'd24);
    for (int k = 0; k < 6; k++) begin
      step();
      check("ign_no_rerun_busy", bus.busy, 1'b0);
      check("ign_no_second_done", bus.done, 1'b0);
    end

    // Back-to-back: start held high, 1s then 2s accepted at E5
    set_ops(8'd1, 8'd1, 8'd1, 8'd1);
    bus.start = 1'b1;
    step();                                   // E0
    check("b2b_busy_e0", bus.busy, 1'b1);
    step(); step(); step();                   // E1..E3
    check("b2b_sum_old", bus.sum, 10'd24);
    step();                                   // E4
    check("b2b_done1", bus.done, 1'b1);
    check("b2b_sum1", bus.sum, 10'd4);
    set_ops(8'd2, 8'd2, 8'd2, 8'd2);
    step();                                   // E5
    check("b2b_busy_e5", bus.busy, 1'b1);
    check("b2b_done_off", bus.done, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();                                 // E6..E8
      check("b2b_sum_hold", bus.sum, 10'd4);
      check("b2b_busy_acc", bus.busy, 1'b1);
    end
    step();                                   // E9
    bus.start = 1'b0;
    check("b2b_done2", bus.done, 1'b1);
    check("b2b_sum2", bus.sum, 10'd8);
    step();
    step();

    // Max run again so the reset below has a nonzero sum/ovf to clear
    run_sum("max2", 8'd255, 8'd255, 8'd255, 8'd255, 10'h3FC, OVF_MAX, 1'b0);

    // Reset mid-ACC after E2
    set_ops(8'd50, 8'd60, 8'd70, 8'd80);
    bus.start = 1'b1;
    step();                                   // E0
    bus.start = 1'b0;
    step();                                   // E1
    step();                                   // E2
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_done", bus.done, 1'b0);
    check("mid_rst_sum", bus.sum, 10'd0);
    check("mid_rst_ovf", bus.ovf, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("mid_rst_no_done", bus.done, 1'b0);
      check("mid_rst_sum_hold", bus.sum, 10'd0);
    end

    // Fresh run after reset works normally
    run_sum("post_rst", 8'd100, 8'd0, 8'd27, 8'd128, 10'd255, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_quad_sum_acc
